// File: rtl/mux_key_table_if.sv
// Table-write and lookup handshake bundle for mux_key_table.
// multi_hit exists only when MUX_KEY_TABLE_MULTIHIT_EN is defined.
interface mux_key_table_if #(
  parameter int NR_KEY   = 8,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8
);
  localparam int IDX_LEN = $clog2(NR_KEY);

  logic                clr;
  logic                wr_en;
  logic [IDX_LEN-1:0]  wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_vld;
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] default_out;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_data;
  logic                resp_hit;
  logic [IDX_LEN-1:0]  resp_idx;
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
  logic                multi_hit;
`endif

  modport master (
    output clr, wr_en, wr_idx, wr_key, wr_data, wr_vld,
    output req_valid, req_key, default_out, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_hit, resp_idx
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
    , input multi_hit
`endif
  );

  modport slave (
    input  clr, wr_en, wr_idx, wr_key, wr_data, wr_vld,
    input  req_valid, req_key, default_out, resp_ready,
    output req_ready, resp_valid, resp_data, resp_hit, resp_idx
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
    , output multi_hit
`endif
  );
endinterface

// File: rtl/mux_key_table.sv
// Runtime-programmable key->data table with a registered valid/ready lookup, lowest index wins.
// Optional MUX_KEY_TABLE_MULTIHIT_EN adds a registered multi_hit flag.
module mux_key_table #(
  parameter int NR_KEY      = 8,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int HAS_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mux_key_table_if.slave   bus
);
  localparam int IDX_LEN = $clog2(NR_KEY);

  logic [NR_KEY-1:0]   valid;
  logic [KEY_LEN-1:0]  key  [NR_KEY];
  logic [DATA_LEN-1:0] data [NR_KEY];

  logic [NR_KEY-1:0]   match;
  logic                hit;
  logic [IDX_LEN-1:0]  hit_idx;
  logic [DATA_LEN-1:0] hit_data;
  logic                accept;
  logic                in_range;

  logic                vld_p1;
  logic [DATA_LEN-1:0] data_p1;
  logic                hit_p1;
  logic [IDX_LEN-1:0]  idx_p1;

  // Guards non-power-of-two tables against writes past the last entry
  assign in_range = ({1'b0, bus.wr_idx} < (IDX_LEN+1)'(NR_KEY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key[i]  <= '0;
        data[i] <= '0;
      end
    end else if (bus.clr) begin
      valid <= '0;
    end else if (bus.wr_en && in_range) begin
      valid[bus.wr_idx] <= bus.wr_vld;
      key[bus.wr_idx]   <= bus.wr_key;
      data[bus.wr_idx]  <= bus.wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = valid[i] && (key[i] == bus.req_key);
    end
  end

`ifdef MUX_KEY_TABLE_MULTIHIT_EN
  logic multi;
  logic multi_p1;
`endif

  // Ascending scan: the first match claims data/idx, any later one flags a multi-hit
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
    multi    = 1'b0;
`endif
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (hit) begin
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
          multi = 1'b1;
`endif
        end else begin
          hit      = 1'b1;
          hit_idx  = IDX_LEN'(i);
          hit_data = data[i];
        end
      end
    end
  end

  assign bus.req_ready = !vld_p1 || bus.resp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Stage p1: registered response; payload only changes on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      hit_p1   <= 1'b0;
      idx_p1   <= '0;
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
      multi_p1 <= 1'b0;
`endif
    end else if (accept) begin
      vld_p1   <= 1'b1;
      data_p1  <= hit ? hit_data : ((HAS_DEFAULT != 0) ? bus.default_out : '0);
      hit_p1   <= hit;
      idx_p1   <= hit_idx;
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
      multi_p1 <= multi;
`endif
    end else if (bus.resp_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.resp_valid = vld_p1;
  assign bus.resp_data  = data_p1;
  assign bus.resp_hit   = hit_p1;
  assign bus.resp_idx   = idx_p1;
`ifdef MUX_KEY_TABLE_MULTIHIT_EN
  assign bus.multi_hit  = multi_p1;
`endif
endmodule
